// File: rtl/daq_pkg.sv
// Shared types and default timing for the AD7606 read sequencer.
// State encoding and default cycle counts live here so tick and sequencer logic agree.
package daq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RD_L,
        ST_RD_H
    } daq_state_e;

    localparam int unsigned DEF_NUM_CH   = 8;
    localparam int unsigned DEF_CONV_LOW = 4;
    localparam int unsigned DEF_RD_LOW   = 3;
    localparam int unsigned DEF_RD_HIGH  = 2;
    localparam int unsigned DEF_BUSY_TO  = 64;

    localparam int unsigned TMR_W = 16;

    // Down-counters load cycles-1 and finish on the cycle they read zero.
    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned cycles);
        return TMR_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ad7606_read_sequencer_if.sv
// ADC parallel bus plus FIFO write port of the AD7606 read sequencer.
// master = sequencer side, slave = ADC/FIFO side.
interface ad7606_read_sequencer_if;
    logic        convst_o;
    logic        cs_n_o;
    logic        rd_n_o;
    logic        busy_i;
    logic        frstdata_i;
    logic [15:0] db_i;
    logic [15:0] wrdata_o;
    logic        wrreq_o;
    logic        wrfull_i;

    modport master (
        output convst_o, cs_n_o, rd_n_o, wrdata_o, wrreq_o,
        input  busy_i, frstdata_i, db_i, wrfull_i
    );

    modport slave (
        input  convst_o, cs_n_o, rd_n_o, wrdata_o, wrreq_o,
        output busy_i, frstdata_i, db_i, wrfull_i
    );
endinterface

// File: rtl/daq_tick_gen.sv
// Conversion trigger: counts 0..period_i and emits a registered one-cycle tick on wrap.
// A zero period or a dropped enable parks the counter at 0 with no ticks.
module daq_tick_gen
    import daq_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [15:0] period_i,
    output logic        tick_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        tick_q, tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (enable_i && (period_i != '0)) begin
            // >= keeps the counter sane if period_i is lowered below the current count
            if (cnt_q >= period_i) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/ad7606_read_sequencer.sv
// AD7606 conversion/readout sequencer: CONVST pulse, BUSY handshake, NUM_CH parallel reads
// into a FIFO, with sticky overrun / missed-trigger / busy-timeout / framing flags.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for a trigger tick
// ST_CONV    | CONVST held low for CONV_LOW cycles
// ST_WAIT_HI | waiting up to BUSY_TO cycles for BUSY to rise
// ST_WAIT_LO | conversion running, waiting for BUSY to fall
// ST_RD_L    | RD low for RD_LOW cycles, sample DB on last cycle
// ST_RD_H    | RD high for RD_HIGH cycles, advance channel
module ad7606_read_sequencer
    import daq_pkg::*;
#(
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned CONV_LOW = DEF_CONV_LOW,
    parameter int unsigned RD_LOW   = DEF_RD_LOW,
    parameter int unsigned RD_HIGH  = DEF_RD_HIGH,
    parameter int unsigned BUSY_TO  = DEF_BUSY_TO
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic [15:0]                    period_i,
    ad7606_read_sequencer_if.master        bus,
    output logic                           overrun_o,
    output logic                           missed_o,
    output logic                           busy_err_o,
    output logic                           frame_err_o,
    input  logic                           clr_i
);

    localparam logic [TMR_W-1:0] CONV_LD  = tmr_load(CONV_LOW);
    localparam logic [TMR_W-1:0] BUSY_LD  = tmr_load(BUSY_TO);
    localparam logic [TMR_W-1:0] RDL_LD   = tmr_load(RD_LOW);
    localparam logic [TMR_W-1:0] RDH_LD   = tmr_load(RD_HIGH);
    localparam logic [3:0]       LAST_IDX = 4'(NUM_CH - 1);

    logic tick;

    daq_tick_gen u_tick (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .period_i (period_i),
        .tick_o   (tick)
    );

    daq_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [3:0]        idx_q, idx_d;
    logic              convst_q, convst_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic [15:0]       wrdata_q, wrdata_d;
    logic              wr_pend_q, wr_pend_d;
    logic              overrun_q, overrun_d;
    logic              missed_q, missed_d;
    logic              busy_err_q, busy_err_d;
    logic              frame_err_q, frame_err_d;
    logic              set_busy_err;
    logic              set_frame_err;

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        idx_d         = idx_q;
        convst_d      = convst_q;
        cs_n_d        = cs_n_q;
        rd_n_d        = rd_n_q;
        wrdata_d      = wrdata_q;
        wr_pend_d     = 1'b0;
        set_busy_err  = 1'b0;
        set_frame_err = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d  = ST_CONV;
                    convst_d = 1'b0;
                    tmr_d    = CONV_LD;
                end
            end
            ST_CONV: begin
                if (tmr_q == '0) begin
                    state_d  = ST_WAIT_HI;
                    convst_d = 1'b1;
                    tmr_d    = BUSY_LD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (bus.busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (tmr_q == '0) begin
                    state_d      = ST_IDLE;
                    set_busy_err = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!bus.busy_i) begin
                    state_d = ST_RD_L;
                    idx_d   = '0;
                    cs_n_d  = 1'b0;
                    rd_n_d  = 1'b0;
                    tmr_d   = RDL_LD;
                end
            end
            ST_RD_L: begin
                if (tmr_q == '0) begin
                    state_d       = ST_RD_H;
                    wrdata_d      = bus.db_i;
                    wr_pend_d     = 1'b1;
                    // FRSTDATA must be high exactly on channel 0
                    set_frame_err = (bus.frstdata_i != (idx_q == '0));
                    rd_n_d        = 1'b1;
                    tmr_d         = RDH_LD;
                    if (idx_q == LAST_IDX) begin
                        cs_n_d = 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_RD_H: begin
                if (tmr_q == '0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_RD_L;
                        idx_d   = idx_q + 4'd1;
                        rd_n_d  = 1'b0;
                        tmr_d   = RDL_LD;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                convst_d = 1'b1;
                cs_n_d   = 1'b1;
                rd_n_d   = 1'b1;
            end
        endcase

        // Sticky flags: a set in the same cycle as clr_i wins
        overrun_d   = (wr_pend_q & bus.wrfull_i) | (overrun_q & ~clr_i);
        missed_d    = (tick & (state_q != ST_IDLE)) | (missed_q & ~clr_i);
        busy_err_d  = set_busy_err | (busy_err_q & ~clr_i);
        frame_err_d = set_frame_err | (frame_err_q & ~clr_i);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            idx_q       <= '0;
            convst_q    <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            wrdata_q    <= '0;
            wr_pend_q   <= 1'b0;
            overrun_q   <= 1'b0;
            missed_q    <= 1'b0;
            busy_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            convst_q    <= convst_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            wrdata_q    <= wrdata_d;
            wr_pend_q   <= wr_pend_d;
            overrun_q   <= overrun_d;
            missed_q    <= missed_d;
            busy_err_q  <= busy_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.convst_o  = convst_q;
    assign bus.cs_n_o    = cs_n_q;
    assign bus.rd_n_o    = rd_n_q;
    assign bus.wrdata_o  = wrdata_q;
    // The FIFO full check has to see the write cycle itself, so the strobe is gated here
    assign bus.wrreq_o   = wr_pend_q & ~bus.wrfull_i;
    assign overrun_o     = overrun_q;
    assign missed_o      = missed_q;
    assign busy_err_o    = busy_err_q;
    assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_ad7606_read_sequencer.sv
// Bench for ad7606_read_sequencer: behavioural AD7606 + FIFO model with a word scoreboard.
// Everything runs in one process; step() advances to the next falling edge and updates the model.
module tb_ad7606_read_sequencer;
    import daq_pkg::*;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned CONV_LOW = 4;
    localparam int unsigned RD_LOW   = 3;
    localparam int unsigned RD_HIGH  = 2;
    localparam int unsigned BUSY_TO  = 64;

    logic        clk_i    = 1'b0;
    logic        reset_i  = 1'b1;
    logic        enable_i = 1'b0;
    logic        clr_i    = 1'b0;
    logic [15:0] period_i = '0;
    logic        overrun_o, missed_o, busy_err_o, frame_err_o;

    ad7606_read_sequencer_if bus();

    ad7606_read_sequencer #(
        .NUM_CH   (NUM_CH),
        .CONV_LOW (CONV_LOW),
        .RD_LOW   (RD_LOW),
        .RD_HIGH  (RD_HIGH),
        .BUSY_TO  (BUSY_TO)
    ) u_dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .period_i    (period_i),
        .bus         (bus),
        .overrun_o   (overrun_o),
        .missed_o    (missed_o),
        .busy_err_o  (busy_err_o),
        .frame_err_o (frame_err_o),
        .clr_i       (clr_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ADC model and scoreboard state
    int          d_cfg = 5, h_cfg = 5;
    bit          no_busy = 0, rand_mode = 0, chk_space = 0;
    logic [7:0]  next_full = '0, next_bad = '0, cur_full = '0, cur_bad = '0;
    int          busy_dly = 0, busy_hold = 0, rd_ch = 0, pres_ch = -1;
    logic [15:0] exp_q[$];
    bit          exp_ovr = 0, exp_frm = 0, exp_missed = 0, exp_berr = 0;
    int          n_conv = 0, wr_cnt = 0, conv_low = 0, rd_low = 0;
    logic        convst_prev = 1'b1, rd_prev = 1'b1;
    int          rise_cyc = 0, last_fall = -1, first_fall = -1, c0 = 0, target = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [15:0] word;
        @(negedge clk_i);
        if (bus.wrreq_o) begin
            wr_cnt++;
            check_eq("wr_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("wr_data", 32'(bus.wrdata_o), 32'(exp_q.pop_front()));
        end
        if (!bus.convst_o) begin
            if (convst_prev) begin
                if (chk_space && last_fall >= 0)
                    check_eq("tick_spacing", 32'(cyc - last_fall), 32'(period_i) + 32'd1);
                last_fall = cyc;
                if (first_fall < 0) first_fall = cyc;
            end
            conv_low++;
        end else if (!convst_prev) begin
            check_eq("convst_low", 32'(conv_low), 32'(CONV_LOW));
            conv_low = 0;
            n_conv++;
            rise_cyc = cyc;
            if (rand_mode) begin
                d_cfg     = $urandom_range(1, 20);
                h_cfg     = $urandom_range(1, 30);
                next_full = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                next_bad  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            cur_full = next_full;
            cur_bad  = next_bad;
            if (!no_busy) busy_dly = d_cfg;
        end
        if (busy_dly > 0) begin
            busy_dly--;
            if (busy_dly == 0) begin
                bus.busy_i = 1'b1;
                busy_hold  = h_cfg;
            end
        end else if (busy_hold > 0) begin
            busy_hold--;
            if (busy_hold == 0) begin
                bus.busy_i = 1'b0;
                rd_ch      = 0;
            end
        end
        if (!bus.rd_n_o) begin
            if (rd_prev && rd_ch < 8) begin
                word           = 16'($urandom);
                bus.db_i       = word;
                bus.frstdata_i = (rd_ch == 0) ^ cur_bad[rd_ch];
                bus.wrfull_i   = cur_full[rd_ch];
                if (!cur_full[rd_ch]) exp_q.push_back(word);
                exp_ovr = exp_ovr | cur_full[rd_ch];
                exp_frm = exp_frm | cur_bad[rd_ch];
                pres_ch = rd_ch;
                rd_ch++;
            end
            rd_low++;
            if (rd_low == 1) check_eq("cs_during_rd", 32'(bus.cs_n_o), 32'd0);
        end else if (rd_low > 0) begin
            check_eq("rd_low", 32'(rd_low), 32'(RD_LOW));
            rd_low = 0;
        end
        convst_prev = bus.convst_o;
        rd_prev     = bus.rd_n_o;
    endtask

    task automatic wait_convs(input int n, input int limit);
        for (int i = 0; i < limit && n_conv < n; i++) step();
        check_eq("conv_count", 32'(n_conv), 32'(n));
    endtask

    task automatic drain();
        enable_i = 1'b0;
        repeat (300) step();
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        bus.wrfull_i = 1'b0;
    endtask

    task automatic check_flags();
        check_eq("overrun",   32'(overrun_o),   32'(exp_ovr));
        check_eq("missed",    32'(missed_o),    32'(exp_missed));
        check_eq("busy_err",  32'(busy_err_o),  32'(exp_berr));
        check_eq("frame_err", 32'(frame_err_o), 32'(exp_frm));
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check_eq("clr_flags", {28'd0, overrun_o, missed_o, busy_err_o, frame_err_o}, 32'd0);
        exp_ovr = 0; exp_frm = 0; exp_missed = 0; exp_berr = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_convst"}, 32'(bus.convst_o), 32'd1);
        check_eq({pfx, "_cs_n"},   32'(bus.cs_n_o),   32'd1);
        check_eq({pfx, "_rd_n"},   32'(bus.rd_n_o),   32'd1);
        check_eq({pfx, "_wrreq"},  32'(bus.wrreq_o),  32'd0);
        check_eq({pfx, "_wrdata"}, 32'(bus.wrdata_o), 32'd0);
        check_eq({pfx, "_flags"},  {28'd0, overrun_o, missed_o, busy_err_o, frame_err_o}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.busy_i     = 1'b0;
        bus.frstdata_i = 1'b0;
        bus.db_i       = '0;
        bus.wrfull_i   = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("rst");
        reset_i = 1'b0;
        step();

        // Nominal run, period 99: 8 in-order writes per 100 cycles, first tick after period+1
        period_i = 16'd99; d_cfg = 20; h_cfg = 10;
        chk_space = 1; last_fall = -1; first_fall = -1; wr_cnt = 0;
        c0 = cyc;
        enable_i = 1'b1;
        wait_convs(4, 600);
        // tick lands period_i+1 cycles after enable is sampled, CONVST falls one cycle later
        check_eq("first_tick_latency", 32'(first_fall - c0), 32'd99 + 32'd2);
        drain();
        check_eq("s1_writes", 32'(wr_cnt), 32'(4 * NUM_CH));
        check_eq("no_tick_after_disable", 32'(n_conv), 32'd4);
        chk_space = 0;
        check_flags();

        // BUSY never rises: timeout after exactly BUSY_TO cycles, then a normal sequence
        no_busy = 1; wr_cnt = 0; period_i = 16'd300;
        enable_i = 1'b1;
        for (int i = 0; i < 600 && !busy_err_o; i++) step();
        check_eq("busy_to_latency", 32'(cyc - rise_cyc), 32'(BUSY_TO));
        check_eq("busy_to_writes", 32'(wr_cnt), 32'd0);
        check_eq("busy_to_cs_n", 32'(bus.cs_n_o), 32'd1);
        no_busy = 0; d_cfg = 7; h_cfg = 12;
        target = n_conv + 1;
        wait_convs(target, 800);
        drain();
        check_eq("recover_writes", 32'(wr_cnt), 32'(NUM_CH));
        exp_berr = 1;
        check_flags();

        // FIFO full during channels 3-4
        next_full = 8'b0001_1000; wr_cnt = 0; period_i = 16'd120;
        target = n_conv + 1;
        enable_i = 1'b1;
        wait_convs(target, 400);
        drain();
        next_full = '0;
        check_eq("ovr_writes", 32'(wr_cnt), 32'd6);
        check_flags();

        // FRSTDATA wrongly high on channel 2
        next_bad = 8'b0000_0100; wr_cnt = 0;
        target = n_conv + 1;
        enable_i = 1'b1;
        wait_convs(target, 400);
        drain();
        next_bad = '0;
        check_eq("frm_writes", 32'(wr_cnt), 32'(NUM_CH));
        check_flags();

        // Period shorter than a sequence: ticks are missed, sequences stay intact
        period_i = 16'd10; d_cfg = 2; h_cfg = 5; wr_cnt = 0;
        target = n_conv + 3;
        enable_i = 1'b1;
        wait_convs(target, 600);
        drain();
        check_eq("missed_writes", 32'(wr_cnt), 32'(3 * NUM_CH));
        exp_missed = ((10 + 1) < (CONV_LOW + NUM_CH * (RD_LOW + RD_HIGH)));
        check_flags();

        // Reset pulse in the middle of channel 4's read strobe
        period_i = 16'd99; d_cfg = 3; h_cfg = 3; pres_ch = -1;
        enable_i = 1'b1;
        for (int i = 0; i < 400 && !(pres_ch == 4 && !bus.rd_n_o); i++) step();
        check_eq("reached_ch4", 32'(pres_ch), 32'd4);
        #2 reset_i = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        bus.busy_i = 1'b0; bus.wrfull_i = 1'b0;
        busy_dly = 0; busy_hold = 0; rd_ch = 0; pres_ch = -1;
        conv_low = 0; rd_low = 0; convst_prev = 1'b1; rd_prev = 1'b1;
        exp_ovr = 0; exp_frm = 0;
        @(negedge clk_i);
        reset_i = 1'b0;
        wr_cnt = 0;
        target = n_conv + 1;
        wait_convs(target, 400);
        drain();
        check_eq("postrst_writes", 32'(wr_cnt), 32'(NUM_CH));
        check_flags();

        // Randomized timing, FIFO-full and framing patterns
        rand_mode = 1; chk_space = 1;
        for (int r = 0; r < 2; r++) begin
            period_i = 16'($urandom_range(150, 300));
            last_fall = -1;
            target = n_conv + 4;
            enable_i = 1'b1;
            wait_convs(target, 1500);
            drain();
            check_flags();
        end
        rand_mode = 0; chk_space = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
